lap_timer: RTL and testbench
============================

LAP_TIMER -- requirements
Module: lap_timer

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000: input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1000: count rate in Hz; CLK_HZ/TICK_HZ SHALL be an integer of at least 2.
REQ-003 Parameter CNT_W, default 20: width of the elapsed count and of each lap entry.
REQ-004 Parameter MAX_COUNT, default 999_999: terminal count, at most 2^CNT_W-1.
REQ-005 Parameter LAP_DEPTH, default 8: lap FIFO depth, a power of two of at least 2.
REQ-006 Parameter WRAP, default 0: 0 saturates at MAX_COUNT; 1 wraps to 0.
REQ-007 Port clk, input, 1: the single clock; all logic SHALL be rising-edge.
REQ-008 Port rst, input, 1: reset, asynchronous and active-high.
REQ-009 Port start_stop, input, 1: debounced single-cycle run/pause request.
REQ-010 Port lap, input, 1: single-cycle lap capture request.
REQ-011 Port clear, input, 1: single-cycle clear request.
REQ-012 Port rd_en, input, 1: pop one lap entry.
REQ-013 Port rd_data, output, CNT_W: popped lap value.
REQ-014 Port rd_valid, output, 1: rd_data is valid this cycle.
REQ-015 Port elapsed, output, CNT_W: current count, registered.
REQ-016 Port tick, output, 1: single-cycle TICK_HZ strobe, active only in RUN.
REQ-017 Port running, output, 1: high in RUN.
REQ-018 Port lap_count, output, $clog2(LAP_DEPTH)+1: FIFO occupancy.
REQ-019 Port full / empty, output, 1 each: FIFO status.
REQ-020 Port ovf, output, 1: sticky flag; set on saturation (WRAP=0), on wrap (WRAP=1), or on lap push while full.

Function
REQ-021 The FSM SHALL have states IDLE, RUN and PAUSE.
REQ-022 The FSM SHALL transition IDLE->RUN, RUN->PAUSE and PAUSE->RUN on start_stop.
REQ-023 clear SHALL force IDLE from any state, zero elapsed, flush the FIFO and clear ovf.
REQ-024 clear SHALL take priority over start_stop, lap and rd_en in the same cycle.
REQ-025 The prescaler SHALL advance only in RUN and SHALL emit tick every CLK_HZ/TICK_HZ clocks.
REQ-026 The prescaler SHALL zero on IDLE->RUN and hold its phase through PAUSE.
REQ-027 On tick, elapsed SHALL increment by 1 on the next edge.
REQ-028 At MAX_COUNT with WRAP=0, elapsed SHALL hold at MAX_COUNT and ovf SHALL set.
REQ-029 At MAX_COUNT with WRAP=1, elapsed SHALL go to 0 and ovf SHALL set.
REQ-030 lap in RUN or PAUSE SHALL push the pre-increment elapsed value of that cycle.
REQ-031 lap in IDLE SHALL be ignored.
REQ-032 lap while full SHALL not push and SHALL set ovf, unless rd_en pops in the same cycle, in which case both the push and the pop SHALL occur.
REQ-033 rd_en while not empty SHALL produce rd_data with rd_valid high one cycle later.
REQ-034 rd_en while empty SHALL be ignored, with rd_valid low.
REQ-035 start_stop and lap in the same cycle SHALL both take effect, with lap capturing the value before the state change.
REQ-036 lap_count, full and empty SHALL update on the edge following a push or pop.

Reset
REQ-037 rst SHALL force, asynchronously: FSM=IDLE, elapsed=0, prescaler=0, FIFO empty (lap_count=0, empty=1, full=0), rd_data=0, rd_valid=0, tick=0, running=0, ovf=0.
REQ-038 rst asserted mid-RUN SHALL discard all laps.
REQ-039 After rst deasserts, the first accepted input SHALL be on the following edge.

Structure
REQ-040 The FSM state enum and the default timing constants (CLK_HZ, TICK_HZ, MAX_COUNT) SHALL reside in time_pkg.
REQ-041 The prescaler SHALL be a sub-module named tick_gen (ports clk, rst, en, restart, tick).
REQ-042 The FIFO SHALL be inline register storage with wrap-around read/write pointers.

Verification (CLK_HZ=10, TICK_HZ=1, MAX_COUNT=5, LAP_DEPTH=4 unless stated)
REQ-043 Apply start_stop, wait 30 clocks, apply start_stop -> elapsed=3, FSM in PAUSE, running=0; a further 20 clocks leave elapsed=3.
REQ-044 Apply lap at elapsed=1, 2, 3, then rd_en x3 -> rd_data 1, 2, 3, each with rd_valid high one cycle after rd_en; empty=1 after the third pop.
REQ-045 Apply 5 laps without reads -> full=1, lap_count=4, ovf=1, fifth value dropped; repeat with rd_en in the same cycle as the fifth lap -> lap_count stays 4, ovf=0.
REQ-046 Run 80 clocks with WRAP=0 -> elapsed=5, ovf=1; with WRAP=1 -> elapsed=1 after 70 clocks, ovf=1.
REQ-047 Apply clear, start_stop and lap in the same cycle during RUN -> IDLE, elapsed=0, empty=1, ovf=0.
REQ-048 Pulse rst for 1 ns between edges during RUN -> all outputs at their REQ-037 values immediately, before the next edge.

Source files
------------

// File: rtl/time_pkg.sv
// Shared state encoding and default timing constants for the lap timer.
package time_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int unsigned DEF_CLK_HZ    = 50_000_000;
    localparam int unsigned DEF_TICK_HZ   = 1000;
    localparam int unsigned DEF_MAX_COUNT = 999_999;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: strobes tick once every DIV enabled clocks; restart zeroes the phase,
// dropping en simply freezes it.
module tick_gen #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int unsigned     CW   = $clog2(DIV);
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Decoded from the counter so elapsed advances on the same edge the phase wraps.
    assign tick = en && !restart && (cnt_q == LAST);

endmodule

// File: rtl/lap_timer.sv
// Stopwatch with run/pause/clear control, prescaled elapsed count and a lap FIFO.
module lap_timer
    import time_pkg::*;
#(
    parameter int unsigned CLK_HZ    = DEF_CLK_HZ,
    parameter int unsigned TICK_HZ   = DEF_TICK_HZ,
    parameter int unsigned CNT_W     = 20,
    parameter int unsigned MAX_COUNT = DEF_MAX_COUNT,
    parameter int unsigned LAP_DEPTH = 8,
    parameter int unsigned WRAP      = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_stop,
    input  logic                         lap,
    input  logic                         clear,
    input  logic                         rd_en,
    output logic [CNT_W-1:0]             rd_data,
    output logic                         rd_valid,
    output logic [CNT_W-1:0]             elapsed,
    output logic                         tick,
    output logic                         running,
    output logic [$clog2(LAP_DEPTH):0]   lap_count,
    output logic                         full,
    output logic                         empty,
    output logic                         ovf
);

    localparam int unsigned     DIV     = CLK_HZ / TICK_HZ;
    localparam int unsigned     AW      = $clog2(LAP_DEPTH);
    localparam int unsigned     PW      = AW + 1;
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_COUNT);
    localparam logic [PW-1:0]   DEPTH_C = PW'(LAP_DEPTH);

    state_t state_q, state_d;

    logic             active;
    logic             restart;
    logic             push;
    logic             pop;

    logic [CNT_W-1:0] elapsed_q, elapsed_d;
    logic             ovf_q, ovf_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0] mem_q [LAP_DEPTH];

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else if (start_stop) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        running = (state_q == ST_RUN);
        active  = (state_q != ST_IDLE);
        restart = clear || (state_q == ST_IDLE);
    end

    tick_gen #(
        .DIV(DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .en      (running),
        .restart (restart),
        .tick    (tick)
    );

    assign lap_count = wr_ptr_q - rd_ptr_q;
    assign full      = (lap_count == DEPTH_C);
    assign empty     = (wr_ptr_q == rd_ptr_q);

    // A pop frees the slot a same-cycle push lands in, so push is allowed when full && pop.
    always_comb begin
        pop        = rd_en && !empty && !clear;
        push       = lap && active && (!full || pop) && !clear;
        elapsed_d  = elapsed_q;
        ovf_d      = ovf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = pop;
        if (clear) begin
            elapsed_d = '0;
            ovf_d     = 1'b0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            rd_data_d = '0;
        end else begin
            if (tick) begin
                if (elapsed_q == MAX_C) begin
                    ovf_d = 1'b1;
                    if (WRAP != 0) begin
                        elapsed_d = '0;
                    end
                end else begin
                    elapsed_d = elapsed_q + CNT_W'(1);
                end
            end
            if (lap && active && full && !pop) begin
                ovf_d = 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + PW'(1);
                rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elapsed_q  <= '0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            elapsed_q  <= elapsed_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= elapsed_q;
        end
    end

    assign elapsed  = elapsed_q;
    assign ovf      = ovf_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_lap_timer.sv
// Self-checking bench for lap_timer: cycle model plus lap scoreboard, WRAP=0 and WRAP=1 instances.
module tb_lap_timer;

    localparam int unsigned DIV   = 10;
    localparam int unsigned MAXC  = 5;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_stop = 1'b0;
    logic lap = 1'b0;
    logic clear = 1'b0;
    logic rd_en = 1'b0;

    logic [CW-1:0] rd_data0, elapsed0, rd_data1, elapsed1;
    logic          rd_valid0, tick0, running0, full0, empty0, ovf0;
    logic          rd_valid1, tick1, running1, full1, empty1, ovf1;
    logic [2:0]    lap_count0, lap_count1;

    always #5 clk = ~clk;

    lap_timer #(
        .CLK_HZ(10), .TICK_HZ(1), .CNT_W(CW), .MAX_COUNT(MAXC), .LAP_DEPTH(DEPTH), .WRAP(0)
    ) u_sat (
        .clk(clk), .rst(rst), .start_stop(start_stop), .lap(lap), .clear(clear), .rd_en(rd_en),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .elapsed(elapsed0), .tick(tick0),
        .running(running0), .lap_count(lap_count0), .full(full0), .empty(empty0), .ovf(ovf0)
    );

    lap_timer #(
        .CLK_HZ(10), .TICK_HZ(1), .CNT_W(CW), .MAX_COUNT(MAXC), .LAP_DEPTH(DEPTH), .WRAP(1)
    ) u_wrap (
        .clk(clk), .rst(rst), .start_stop(start_stop), .lap(lap), .clear(clear), .rd_en(rd_en),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .elapsed(elapsed1), .tick(tick1),
        .running(running1), .lap_count(lap_count1), .full(full1), .empty(empty1), .ovf(ovf1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model of the WRAP=0 instance; sb holds the expected FIFO contents.
    int unsigned m_state;
    int unsigned m_cnt;
    int unsigned m_el;
    bit          m_ovf;
    bit          m_rdv;
    int unsigned m_rdd;
    int unsigned sb[$];

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_el    = 0;
        m_ovf   = 1'b0;
        m_rdv   = 1'b0;
        m_rdd   = 0;
        sb.delete();
    endtask

    task automatic model_step(input bit ss, input bit lp, input bit clr, input bit rd);
        bit tk;
        tk    = (m_state == 1) && (m_cnt == DIV - 1);
        m_rdv = 1'b0;
        if (clr) begin
            m_state = 0;
            m_cnt   = 0;
            m_el    = 0;
            m_ovf   = 1'b0;
            sb.delete();
        end else begin
            if (rd && sb.size() > 0) begin
                m_rdv = 1'b1;
                m_rdd = sb.pop_front();
            end
            if (lp && m_state != 0) begin
                if (sb.size() < DEPTH) sb.push_back(m_el);
                else m_ovf = 1'b1;
            end
            if (tk) begin
                if (m_el == MAXC) m_ovf = 1'b1;
                else m_el = m_el + 1;
            end
            if (m_state == 0) m_cnt = 0;
            else if (m_state == 1) m_cnt = (m_cnt == DIV - 1) ? 0 : m_cnt + 1;
            if (ss) m_state = (m_state == 1) ? 2 : 1;
        end
    endtask

    task automatic cyc(input bit ss, input bit lp, input bit clr, input bit rd);
        start_stop = ss;
        lap        = lp;
        clear      = clr;
        rd_en      = rd;
        model_step(ss, lp, clr, rd);
        @(posedge clk);
        #1;
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
        rd_en      = 1'b0;
        check("elapsed", 32'(elapsed0), m_el);
        check("running", 32'(running0), 32'(m_state == 1));
        check("lap_count", 32'(lap_count0), 32'(sb.size()));
        check("ovf", 32'(ovf0), 32'(m_ovf));
        check("tick", 32'(tick0), 32'((m_state == 1) && (m_cnt == DIV - 1)));
        check("rd_valid", 32'(rd_valid0), 32'(m_rdv));
        if (m_rdv) check("rd_data", 32'(rd_data0), m_rdd);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_to(input int unsigned v);
        for (int i = 0; i < 200 && m_el != v; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_elapsed", 32'(elapsed0), 0);
        check("rst_running", 32'(running0), 0);
        check("rst_empty", 32'(empty0), 1);
        check("rst_full", 32'(full0), 0);
        check("rst_lap_count", 32'(lap_count0), 0);
        check("rst_ovf", 32'(ovf0), 0);
        check("rst_rd_valid", 32'(rd_valid0), 0);
        check("rst_rd_data", 32'(rd_data0), 0);
        check("rst_tick", 32'(tick0), 0);
        rst = 1'b0;

        // run 30 clocks then pause, pause holds the count
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(29);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("pause_elapsed", 32'(elapsed0), 3);
        check("pause_running", 32'(running0), 0);
        idle(20);
        check("pause_hold", 32'(elapsed0), 3);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(12);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("clear_empty", 32'(empty0), 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("idle_lap_ignored", 32'(empty0), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("empty_rd_valid", 32'(rd_valid0), 0);

        // laps at elapsed 1, 2, 3 then read back
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        run_to(1);
        idle(2);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        run_to(2);
        idle(3);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        run_to(3);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("three_laps", 32'(lap_count0), 3);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("pop1", 32'(rd_data0), 1);
        idle(1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("pop2", 32'(rd_data0), 2);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("pop3", 32'(rd_data0), 3);
        check("pop3_empty", 32'(empty0), 1);

        // five laps into a depth-4 FIFO
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            if (i < 4) idle(7);
        end
        check("over_full", 32'(full0), 1);
        check("over_count", 32'(lap_count0), 4);
        check("over_ovf", 32'(ovf0), 1);
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("over_drained", 32'(empty0), 1);

        // fifth lap with a simultaneous pop
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            idle(3);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        check("pushpop_count", 32'(lap_count0), 4);
        check("pushpop_ovf", 32'(ovf0), 0);
        check("pushpop_full", 32'(full0), 1);
        repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // terminal count: wrap instance after 70, saturating instance after 80
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(70);
        check("wrap_elapsed", 32'(elapsed1), 1);
        check("wrap_ovf", 32'(ovf1), 1);
        idle(10);
        check("sat_elapsed", 32'(elapsed0), 5);
        check("sat_ovf", 32'(ovf0), 1);

        // clear beats start_stop and lap
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        check("clr_running", 32'(running0), 0);
        check("clr_elapsed", 32'(elapsed0), 0);
        check("clr_empty", 32'(empty0), 1);
        check("clr_ovf", 32'(ovf0), 0);
        idle(12);
        check("clr_idle_hold", 32'(elapsed0), 0);

        // asynchronous reset pulse mid-run
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(12);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        check("pre_rst_laps", 32'(lap_count0), 2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_elapsed", 32'(elapsed0), 0);
        check("arst_running", 32'(running0), 0);
        check("arst_lap_count", 32'(lap_count0), 0);
        check("arst_empty", 32'(empty0), 1);
        check("arst_full", 32'(full0), 0);
        check("arst_ovf", 32'(ovf0), 0);
        check("arst_rd_valid", 32'(rd_valid0), 0);
        check("arst_rd_data", 32'(rd_data0), 0);
        check("arst_tick", 32'(tick0), 0);
        check("arst_wrap_elapsed", 32'(elapsed1), 0);
        rst = 1'b0;
        model_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(11);
        check("post_rst_elapsed", 32'(elapsed0), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
